// File: rtl/mem_access_controller_if.sv
// Bundle of the operation handshake, RAM port and write-back signals around mem_access_controller.
// Handshake: an operation is accepted on a rising edge where op_valid && op_ready; op_ready is never gated by op_valid.
interface mem_access_controller_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16,
  parameter int PC_W   = 8,
  parameter int OPC_W  = 4
);
  logic              op_valid;
  logic              op_ready;
  logic [OPC_W-1:0]  opcode;
  logic [DATA_W-1:0] src1;
  logic [DATA_W-1:0] src2;
  logic [DATA_W-1:0] st_data;
  logic [DATA_W-1:0] alu_result;
  logic [PC_W-1:0]   pc;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_rw;
  logic              ram_en;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic              wb_valid;
  logic [DATA_W-1:0] wb_data;
  logic              op_done;
  logic              addr_err;
  logic              stall;

  modport master (
    output op_valid, opcode, src1, src2, st_data, alu_result, pc, ram_rdata,
    input  op_ready, ram_addr, ram_rw, ram_en, ram_wdata, wb_valid, wb_data, op_done, addr_err, stall
  );

  modport slave (
    input  op_valid, opcode, src1, src2, st_data, alu_result, pc, ram_rdata,
    output op_ready, ram_addr, ram_rw, ram_en, ram_wdata, wb_valid, wb_data, op_done, addr_err, stall
  );
endinterface

// File: rtl/mem_access_controller.sv
// Arbitrates a single-port RAM between instruction fetch and LDR/STR data access,
// holding the port for WAIT_STATES cycles and muxing the write-back bus.
module mem_access_controller #(
  parameter int                DATA_W      = 32,
  parameter int                ADDR_W      = 16,
  parameter int                PC_W        = 8,
  parameter int                OPC_W       = 4,
  parameter logic [OPC_W-1:0]  OPC_LDR     = 4'b1000,
  parameter logic [OPC_W-1:0]  OPC_STR     = 4'b1001,
  parameter int                WAIT_STATES = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  mem_access_controller_if.slave     bus,
  output logic [1:0]                 dbg_state_o
);
  localparam int CNT_W = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACCESS = 2'd1, S_DONE = 2'd2} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] ea_q, ea_d;
  logic              is_ldr_q, is_ldr_d;
  logic [DATA_W-1:0] st_data_q, st_data_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic              wb_valid_q, wb_valid_d;
  logic              addr_err_q, addr_err_d;

  logic              accept;
  logic              is_mem;
  logic [DATA_W-1:0] ea_full;
  logic              range_bad;

  assign accept    = bus.op_valid && bus.op_ready;
  assign is_mem    = (bus.opcode == OPC_LDR) || (bus.opcode == OPC_STR);
  // Carry out of the top bit is dropped; only bits above the RAM address range are checked.
  assign ea_full   = bus.src1 + bus.src2;
  assign range_bad = (ea_full >> ADDR_W) != '0;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ea_d       = ea_q;
    is_ldr_d   = is_ldr_q;
    st_data_d  = st_data_q;
    wb_data_d  = wb_data_q;
    wb_valid_d = 1'b0;
    addr_err_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (!is_mem) begin
            wb_data_d  = bus.alu_result;
            wb_valid_d = 1'b1;
            state_d    = S_DONE;
          end else if (range_bad) begin
            addr_err_d = 1'b1;
            state_d    = S_DONE;
          end else begin
            ea_d      = ea_full[ADDR_W-1:0];
            is_ldr_d  = (bus.opcode == OPC_LDR);
            st_data_d = bus.st_data;
            cnt_d     = CNT_W'(WAIT_STATES - 1);
            state_d   = S_ACCESS;
          end
        end
      end
      S_ACCESS: begin
        if (cnt_q == '0) begin
          if (is_ldr_q) begin
            wb_data_d  = bus.ram_rdata;
            wb_valid_d = 1'b1;
          end
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      ea_q       <= '0;
      is_ldr_q   <= 1'b0;
      st_data_q  <= '0;
      wb_data_q  <= '0;
      wb_valid_q <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ea_q       <= ea_d;
      is_ldr_q   <= is_ldr_d;
      st_data_q  <= st_data_d;
      wb_data_q  <= wb_data_d;
      wb_valid_q <= wb_valid_d;
      addr_err_q <= addr_err_d;
    end
  end

  // Outside ACCESS the port always carries the instruction fetch.
  always_comb begin
    bus.ram_en    = 1'b1;
    bus.ram_addr  = ADDR_W'(bus.pc);
    bus.ram_rw    = 1'b1;
    bus.ram_wdata = '0;
    if (state_q == S_ACCESS) begin
      bus.ram_addr  = ea_q;
      bus.ram_rw    = is_ldr_q;
      bus.ram_wdata = is_ldr_q ? '0 : st_data_q;
    end
  end

  assign bus.op_ready = (state_q == S_IDLE) && rst_n;
  assign bus.stall    = (state_q != S_IDLE);
  assign bus.op_done  = (state_q == S_DONE);
  assign bus.wb_valid = wb_valid_q;
  assign bus.addr_err = addr_err_q;
  assign bus.wb_data  = wb_data_q;
  assign dbg_state_o  = state_q;
endmodule

// File: tb/tb_mem_access_controller.sv
// Randomized bench for mem_access_controller: a per-operation cycle schedule model checked every
// cycle, plus directed literal checks for reset, LDR, STR, ALU, range error and mid-access reset.
module tb_mem_access_controller;
  localparam int WS = 2;
  localparam logic [3:0] LDR = 4'b1000;
  localparam logic [3:0] STR = 4'b1001;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] dbg_state;
  int checks = 0;
  int errors = 0;

  mem_access_controller_if bus ();

  mem_access_controller dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  always #5 clk = ~clk;

  // One expected cycle of controller outputs.
  typedef struct packed {
    logic        idle;
    logic        fetch;
    logic [15:0] addr;
    logic        rw;
    logic [31:0] wdata;
    logic        wbv;
    logic        done;
    logic        err;
    logic        capture;
    logic        wb_load;
    logic [31:0] wb_val;
  } rec_t;

  rec_t        exp_q[$];
  rec_t        cur;
  logic [31:0] wb_m = '0;
  bit          started = 0;

  function automatic rec_t idle_rec();
    rec_t r;
    r = '0;
    r.idle = 1'b1;
    r.fetch = 1'b1;
    r.rw = 1'b1;
    return r;
  endfunction

  function automatic rec_t done_rec(input logic wbv, input logic err);
    rec_t r;
    r = '0;
    r.fetch = 1'b1;
    r.rw = 1'b1;
    r.done = 1'b1;
    r.wbv = wbv;
    r.err = err;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Expand each accepted operation into its full cycle-by-cycle schedule.
  task automatic schedule_op();
    logic [31:0] ea;
    rec_t r;
    if (bus.opcode == LDR || bus.opcode == STR) begin
      ea = bus.src1 + bus.src2;
      if (ea > 32'h0000_FFFF) begin
        exp_q.push_back(done_rec(1'b0, 1'b1));
      end else begin
        for (int i = 0; i < WS; i++) begin
          r = '0;
          r.addr = ea[15:0];
          r.rw = (bus.opcode == LDR);
          r.wdata = (bus.opcode == STR) ? bus.st_data : 32'h0;
          r.capture = (bus.opcode == LDR) && (i == WS - 1);
          exp_q.push_back(r);
        end
        exp_q.push_back(done_rec(bus.opcode == LDR, 1'b0));
      end
    end else begin
      r = done_rec(1'b1, 1'b0);
      r.wb_load = 1'b1;
      r.wb_val = bus.alu_result;
      exp_q.push_back(r);
    end
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      cur = idle_rec();
      wb_m = '0;
      started = 1;
    end else begin
      if (cur.capture) wb_m = bus.ram_rdata;
      if (cur.idle && bus.op_valid) schedule_op();
      if (exp_q.size() > 0) begin
        cur = exp_q.pop_front();
        if (cur.wb_load) wb_m = cur.wb_val;
      end else begin
        cur = idle_rec();
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("ram_addr", 32'(bus.ram_addr), cur.fetch ? 32'(bus.pc) : 32'(cur.addr));
      check("ram_rw", 32'(bus.ram_rw), 32'(cur.rw));
      check("ram_en", 32'(bus.ram_en), 32'h1);
      check("ram_wdata", bus.ram_wdata, cur.wdata);
      check("wb_valid", 32'(bus.wb_valid), 32'(cur.wbv));
      check("wb_data", bus.wb_data, wb_m);
      check("op_done", 32'(bus.op_done), 32'(cur.done));
      check("addr_err", 32'(bus.addr_err), 32'(cur.err));
      check("stall", 32'(bus.stall), 32'(!cur.idle));
      check("op_ready", 32'(bus.op_ready), 32'(cur.idle && rst_n));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [3:0] opc, input logic [31:0] s1, input logic [31:0] s2,
                        input logic [31:0] st, input logic [31:0] alu);
    bus.op_valid = 1'b1;
    bus.opcode = opc;
    bus.src1 = s1;
    bus.src2 = s2;
    bus.st_data = st;
    bus.alu_result = alu;
  endtask

  task automatic randomize_inputs();
    logic [3:0] opc;
    logic [31:0] s1, s2;
    case ($urandom_range(0, 3))
      0: opc = LDR;
      1: opc = STR;
      default: opc = 4'($urandom_range(0, 15));
    endcase
    case ($urandom_range(0, 7))
      0: begin s1 = $urandom(); s2 = $urandom(); end
      1: begin s1 = 32'hFFFF_FFF0; s2 = 32'($urandom_range(16, 64)); end
      2: begin s1 = 32'h0000_FFFF; s2 = 32'($urandom_range(0, 2)); end
      default: begin s1 = 32'($urandom_range(0, 16'h7FFF)); s2 = 32'($urandom_range(0, 16'h7FFF)); end
    endcase
    set_op(opc, s1, s2, $urandom(), $urandom());
    bus.op_valid = ($urandom_range(0, 2) != 0);
    bus.pc = 8'($urandom_range(0, 255));
    bus.ram_rdata = $urandom();
    rst_n = ($urandom_range(0, 79) != 0);
  endtask

  initial begin
    bus.op_valid = 1'b0;
    bus.opcode = '0;
    bus.src1 = '0;
    bus.src2 = '0;
    bus.st_data = '0;
    bus.alu_result = '0;
    bus.pc = 8'h05;
    bus.ram_rdata = 32'h8;
    rst_n = 1'b0;

    // Reset: two cycles low, fetch of pc on the port.
    tick();
    tick();
    @(negedge clk);
    check("rst ram_addr", 32'(bus.ram_addr), 32'h0005);
    check("rst ram_rw", 32'(bus.ram_rw), 32'h1);
    check("rst ram_en", 32'(bus.ram_en), 32'h1);
    check("rst wb_valid", 32'(bus.wb_valid), 32'h0);
    check("rst op_ready", 32'(bus.op_ready), 32'h0);
    tick();
    rst_n = 1'b1;

    // LDR 3+0x21 -> 0x24, read for two cycles, data 0x8 on the third.
    set_op(LDR, 32'h3, 32'h21, 32'h0, 32'h0);
    tick();
    bus.op_valid = 1'b0;
    for (int i = 0; i < WS; i++) begin
      @(negedge clk);
      check("ldr ram_addr", 32'(bus.ram_addr), 32'h0024);
      check("ldr ram_rw", 32'(bus.ram_rw), 32'h1);
      check("ldr wb_valid early", 32'(bus.wb_valid), 32'h0);
      tick();
    end
    @(negedge clk);
    check("ldr wb_valid", 32'(bus.wb_valid), 32'h1);
    check("ldr wb_data", bus.wb_data, 32'h8);
    check("ldr op_done", 32'(bus.op_done), 32'h1);
    tick();

    // STR 0x0C+0x09 -> 0x15 with data 0x38.
    set_op(STR, 32'h0C, 32'h09, 32'h38, 32'h0);
    tick();
    bus.op_valid = 1'b0;
    for (int i = 0; i < WS; i++) begin
      @(negedge clk);
      check("str ram_addr", 32'(bus.ram_addr), 32'h0015);
      check("str ram_rw", 32'(bus.ram_rw), 32'h0);
      check("str ram_wdata", bus.ram_wdata, 32'h38);
      tick();
    end
    @(negedge clk);
    check("str op_done", 32'(bus.op_done), 32'h1);
    check("str wb_valid", 32'(bus.wb_valid), 32'h0);
    check("str wb_data held", bus.wb_data, 32'h8);
    tick();

    // ALU op: result on the bus one cycle after accept, no RAM write.
    set_op(4'b1010, 32'h0, 32'h0, 32'h0, 32'h1234);
    tick();
    bus.op_valid = 1'b0;
    @(negedge clk);
    check("alu wb_data", bus.wb_data, 32'h1234);
    check("alu wb_valid", 32'(bus.wb_valid), 32'h1);
    check("alu op_done", 32'(bus.op_done), 32'h1);
    check("alu ram_rw", 32'(bus.ram_rw), 32'h1);
    tick();

    // Out-of-range LDR: error pulse, no access, no write-back.
    set_op(LDR, 32'h0001_0000, 32'h0, 32'h0, 32'h0);
    tick();
    bus.op_valid = 1'b0;
    @(negedge clk);
    check("rng addr_err", 32'(bus.addr_err), 32'h1);
    check("rng op_done", 32'(bus.op_done), 32'h1);
    check("rng ram_rw", 32'(bus.ram_rw), 32'h1);
    check("rng wb_valid", 32'(bus.wb_valid), 32'h0);
    tick();

    // Reset in the middle of a STR; op_valid held high while busy.
    set_op(STR, 32'h10, 32'h20, 32'hABCD, 32'h0);
    bus.pc = 8'h42;
    tick();
    @(negedge clk);
    check("busy op_ready", 32'(bus.op_ready), 32'h0);
    check("busy ram_rw", 32'(bus.ram_rw), 32'h0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    bus.op_valid = 1'b0;
    @(negedge clk);
    check("abort ram_rw", 32'(bus.ram_rw), 32'h1);
    check("abort ram_addr", 32'(bus.ram_addr), 32'h0042);
    check("abort op_done", 32'(bus.op_done), 32'h0);
    check("abort wb_data", bus.wb_data, 32'h0);
    tick();
    @(negedge clk);
    check("abort op_done later", 32'(bus.op_done), 32'h0);

    // Randomized traffic checked by the schedule model.
    for (int i = 0; i < 3000; i++) begin
      tick();
      randomize_inputs();
    end
    tick();
    rst_n = 1'b1;
    bus.op_valid = 1'b0;
    repeat (6) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
